// File: rtl/arith_issue_queue_pkg.sv
// arith_issue_queue_pkg: shared widths, opcodes, entry types and dispatch-operand capture helper
package arith_issue_queue_pkg;
  localparam int XLEN = 32;
  localparam int TAG_W = 4;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_OP = 7'h33;
  typedef struct packed {
    logic rdy;
    logic [XLEN-1:0] val;
    logic [TAG_W-1:0] tag;
  } opnd_t;
  typedef struct packed {
    logic valid;
    logic [XLEN-1:0] pc;
    logic [31:0] inst;
    logic [TAG_W-1:0] tag;
    opnd_t rs1;
    opnd_t rs2;
  } entry_t;
  // A dispatching operand that matches the same-cycle broadcast is stored already ready.
  function automatic opnd_t capture_opnd(input logic rdy, input logic [XLEN-1:0] val,
                                         input logic [TAG_W-1:0] tag, input logic cdb_v,
                                         input logic [TAG_W-1:0] cdb_tag, input logic [XLEN-1:0] cdb_val);
    logic hit;
    hit = !rdy & cdb_v & (tag == cdb_tag);
    return '{rdy: rdy | hit, val: hit ? cdb_val : val, tag: tag};
  endfunction
endpackage

// File: rtl/arith_issue_queue_if.sv
// arith_issue_queue_if: dispatch, CDB, arith and result-slot signals of the arith issue queue
interface arith_issue_queue_if;
  import arith_issue_queue_pkg::*;
  logic dispatch_valid_i, dispatch_ready_o;
  logic [XLEN-1:0] dispatch_pc_i;
  logic [31:0] dispatch_inst_i;
  logic [TAG_W-1:0] dispatch_tag_i;
  logic dispatch_rs1_rdy_i, dispatch_rs2_rdy_i;
  logic [XLEN-1:0] dispatch_rs1_val_i, dispatch_rs2_val_i;
  logic [TAG_W-1:0] dispatch_rs1_tag_i, dispatch_rs2_tag_i;
  logic cdb_valid_i;
  logic [TAG_W-1:0] cdb_tag_i;
  logic [XLEN-1:0] cdb_value_i;
  logic alu_request_o;
  logic [XLEN-1:0] alu_pc_o;
  logic [31:0] alu_inst_o;
  logic [XLEN-1:0] alu_rs1_value_o, alu_rs2_value_o;
  logic alu_writeback_valid_i;
  logic [XLEN-1:0] alu_writeback_value_i;
  logic result_valid_o, result_ready_i;
  logic [TAG_W-1:0] result_tag_o;
  logic [XLEN-1:0] result_value_o;
  modport slave (
    input dispatch_valid_i, dispatch_pc_i, dispatch_inst_i, dispatch_tag_i,
          dispatch_rs1_rdy_i, dispatch_rs2_rdy_i, dispatch_rs1_val_i, dispatch_rs2_val_i,
          dispatch_rs1_tag_i, dispatch_rs2_tag_i, cdb_valid_i, cdb_tag_i, cdb_value_i,
          alu_writeback_valid_i, alu_writeback_value_i, result_ready_i,
    output dispatch_ready_o, alu_request_o, alu_pc_o, alu_inst_o, alu_rs1_value_o,
           alu_rs2_value_o, result_valid_o, result_tag_o, result_value_o
  );
  modport master (
    output dispatch_valid_i, dispatch_pc_i, dispatch_inst_i, dispatch_tag_i,
           dispatch_rs1_rdy_i, dispatch_rs2_rdy_i, dispatch_rs1_val_i, dispatch_rs2_val_i,
           dispatch_rs1_tag_i, dispatch_rs2_tag_i, cdb_valid_i, cdb_tag_i, cdb_value_i,
           alu_writeback_valid_i, alu_writeback_value_i, result_ready_i,
    input dispatch_ready_o, alu_request_o, alu_pc_o, alu_inst_o, alu_rs1_value_o,
          alu_rs2_value_o, result_valid_o, result_tag_o, result_value_o
  );
endinterface

// File: rtl/arith_issue_queue_rr_picker.sv
// rr_picker: round-robin priority encoder, first request at or after ptr_i (wrapping)
module rr_picker #(
  parameter int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [N-1:0] gnt_o,
  output logic [W-1:0] idx_o,
  output logic         valid_o
);
  logic [W-1:0] j;
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    valid_o = 1'b0;
    j = '0;
    for (int i = 0; i < N; i++) begin
      j = ptr_i + W'(i);
      if (!valid_o && req_i[j]) begin
        valid_o = 1'b1;
        idx_o = j;
        gnt_o[j] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/arith_issue_queue.sv
// arith_issue_queue: ALU reservation station with CDB wakeup, round-robin issue and result slot
// Define ARITH_ISSUE_WAKEUP_BYPASS_EN to let an entry issue in the same cycle as its last wakeup.
module arith_issue_queue
  import arith_issue_queue_pkg::*;
#(
  parameter int NUM_ENTRIES = 4
) (
  input logic clk_i,
  input logic reset_ni,
  input logic flush_i,
  arith_issue_queue_if.slave io
);
  localparam int IW = $clog2(NUM_ENTRIES);
  entry_t [NUM_ENTRIES-1:0] ent_q, ent_d;
  entry_t ge, new_ent;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d, gidx, fidx;
  logic [NUM_ENTRIES-1:0] req, gnt, m1, m2;
  logic any_req, any_free, issue, res_valid_q, res_valid_d;
  logic [TAG_W-1:0] res_tag_q, res_tag_d;
  logic [XLEN-1:0] res_value_q, res_value_d, rs1_v, rs2_v;

  rr_picker #(.N(NUM_ENTRIES)) u_pick (
    .req_i(req), .ptr_i(rr_ptr_q), .gnt_o(gnt), .idx_o(gidx), .valid_o(any_req)
  );

  always_comb begin
    m1 = '0;
    m2 = '0;
    req = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      m1[i] = io.cdb_valid_i & ent_q[i].valid & !ent_q[i].rs1.rdy & (ent_q[i].rs1.tag == io.cdb_tag_i);
      m2[i] = io.cdb_valid_i & ent_q[i].valid & !ent_q[i].rs2.rdy & (ent_q[i].rs2.tag == io.cdb_tag_i);
`ifdef ARITH_ISSUE_WAKEUP_BYPASS_EN
      req[i] = ent_q[i].valid & (ent_q[i].rs1.rdy | m1[i]) & (ent_q[i].rs2.rdy | m2[i]);
`else
      req[i] = ent_q[i].valid & ent_q[i].rs1.rdy & ent_q[i].rs2.rdy;
`endif
    end
  end

  always_comb begin
    fidx = '0;
    any_free = 1'b0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (!ent_q[i].valid) begin
        fidx = IW'(i);
        any_free = 1'b1;
      end
    end
  end

  assign ge = ent_q[gidx];
  assign issue = any_req & (!res_valid_q | io.result_ready_i) & !flush_i;
  // Only slots free at the start of the cycle are offered; an issuing slot frees next cycle.
  assign io.dispatch_ready_o = any_free & !flush_i;

`ifdef ARITH_ISSUE_WAKEUP_BYPASS_EN
  assign rs1_v = ge.rs1.rdy ? ge.rs1.val : io.cdb_value_i;
  assign rs2_v = ge.rs2.rdy ? ge.rs2.val : io.cdb_value_i;
`else
  assign rs1_v = ge.rs1.val;
  assign rs2_v = ge.rs2.val;
`endif

  assign io.alu_request_o = issue;
  assign io.alu_pc_o = issue ? ge.pc : '0;
  assign io.alu_inst_o = issue ? ge.inst : '0;
  assign io.alu_rs1_value_o = issue ? rs1_v : '0;
  assign io.alu_rs2_value_o = issue ? rs2_v : '0;
  assign io.result_valid_o = res_valid_q;
  assign io.result_tag_o = res_tag_q;
  assign io.result_value_o = res_value_q;

  always_comb begin
    new_ent = '{valid: 1'b1, pc: io.dispatch_pc_i, inst: io.dispatch_inst_i, tag: io.dispatch_tag_i,
                rs1: capture_opnd(io.dispatch_rs1_rdy_i, io.dispatch_rs1_val_i, io.dispatch_rs1_tag_i,
                                  io.cdb_valid_i, io.cdb_tag_i, io.cdb_value_i),
                rs2: capture_opnd(io.dispatch_rs2_rdy_i, io.dispatch_rs2_val_i, io.dispatch_rs2_tag_i,
                                  io.cdb_valid_i, io.cdb_tag_i, io.cdb_value_i)};
    ent_d = ent_q;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (m1[i]) ent_d[i].rs1 = '{rdy: 1'b1, val: io.cdb_value_i, tag: ent_q[i].rs1.tag};
      if (m2[i]) ent_d[i].rs2 = '{rdy: 1'b1, val: io.cdb_value_i, tag: ent_q[i].rs2.tag};
      if (issue && gnt[i]) ent_d[i].valid = 1'b0;
    end
    if (io.dispatch_valid_i && io.dispatch_ready_o) ent_d[fidx] = new_ent;
    for (int i = 0; i < NUM_ENTRIES; i++) ent_d[i].valid = ent_d[i].valid & !flush_i;
  end

  always_comb begin
    rr_ptr_d = issue ? gidx + IW'(1) : rr_ptr_q;
    res_valid_d = flush_i ? 1'b0 : io.alu_writeback_valid_i ? 1'b1 : io.result_ready_i ? 1'b0 : res_valid_q;
    res_tag_d = io.alu_writeback_valid_i ? ge.tag : res_tag_q;
    res_value_d = io.alu_writeback_valid_i ? io.alu_writeback_value_i : res_value_q;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      ent_q <= '0;
      rr_ptr_q <= '0;
      res_valid_q <= 1'b0;
      res_tag_q <= '0;
      res_value_q <= '0;
    end else begin
      ent_q <= ent_d;
      rr_ptr_q <= rr_ptr_d;
      res_valid_q <= res_valid_d;
      res_tag_q <= res_tag_d;
      res_value_q <= res_value_d;
    end
  end
endmodule
